// File: rtl/multicycle_control_unit.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/HALT sequencer that produces datapath strobes
// from the state and the instruction captured in DECODE.
module multicycle_control_unit #(
  parameter int unsigned IR_W        = 16,
  parameter int unsigned OP_W        = 5,
  parameter int unsigned REG_SEL_W   = 3,
  parameter int unsigned PC_W        = 9,
  parameter int unsigned FLAGS_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IR_W-1:0]      in_ir,
  input  logic [FLAGS_W-1:0]   in_alu_flags,
  input  logic                 in_mem_ready,
  output logic [2:0]           out_alu_op,
  output logic                 out_alu_enable_out,
  output logic                 out_pc_load,
  output logic                 out_pc_inc,
  output logic                 out_pc_enable_out,
  output logic                 out_ir_load,
  output logic                 out_ir_enable_read,
  output logic                 out_mbs_wr_enable,
  output logic                 out_data_memory_read_enable,
  output logic                 out_data_memory_wr_enable,
  output logic                 out_data_memory_addr_wr_enable,
  output logic                 out_reg_write_en,
  output logic                 out_reg_read_en,
  output logic [REG_SEL_W-1:0] out_reg_rx_selector,
  output logic [REG_SEL_W-1:0] out_reg_ry_selector,
  output logic [2:0]           out_state,
  output logic                 out_halted,
  output logic                 out_illegal,
  output logic                 out_mem_timeout,
  output logic [CNT_W-1:0]     out_retired_count
);

  localparam int unsigned CondW = (FLAGS_W > 1) ? $clog2(FLAGS_W) : 1;
  localparam int unsigned TmoW  = $clog2(MEM_TIMEOUT + 1);

  if (!(OP_W >= 4 && OP_W + 2 * REG_SEL_W <= IR_W &&
        OP_W + PC_W + $clog2(FLAGS_W) <= IR_W && MEM_TIMEOUT >= 1)) begin : gen_param_check
    $error("multicycle_control_unit: unsupported parameter combination");
  end

  localparam logic [OP_W-1:0] OpMov    = OP_W'(8);
  localparam logic [OP_W-1:0] OpLoad   = OP_W'(9);
  localparam logic [OP_W-1:0] OpStore  = OP_W'(10);
  localparam logic [OP_W-1:0] OpSetmbs = OP_W'(11);
  localparam logic [OP_W-1:0] OpJmp    = OP_W'(12);
  localparam logic [OP_W-1:0] OpJcond  = OP_W'(13);
  localparam logic [OP_W-1:0] OpNop    = OP_W'(14);
  localparam logic [OP_W-1:0] OpHalt   = OP_W'(15);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StHalt   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [OP_W-1:0]      op_q;
  logic [REG_SEL_W-1:0] rx_q, ry_q;
  logic [CondW-1:0]     cond_q;
  logic [TmoW-1:0]      mem_cnt_q, mem_cnt_d;
  logic                 tmo_q, tmo_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 retire;
  logic                 is_alu;
  logic [OP_W-1:0]      in_op;

  // Only the decoded fields are kept; the rest of the word belongs to the datapath.
  logic unused_ir;
  assign unused_ir = ^in_ir;

  assign in_op  = in_ir[IR_W-1 -: OP_W];
  assign is_alu = (op_q < OP_W'(8));

  always_comb begin
    state_d                        = state_q;
    mem_cnt_d                      = '0;
    tmo_d                          = 1'b0;
    retire                         = 1'b0;
    out_alu_op                     = '0;
    out_alu_enable_out             = 1'b0;
    out_pc_load                    = 1'b0;
    out_pc_inc                     = 1'b0;
    out_pc_enable_out              = 1'b0;
    out_ir_load                    = 1'b0;
    out_ir_enable_read             = 1'b0;
    out_mbs_wr_enable              = 1'b0;
    out_data_memory_read_enable    = 1'b0;
    out_data_memory_wr_enable      = 1'b0;
    out_data_memory_addr_wr_enable = 1'b0;
    out_reg_write_en               = 1'b0;
    out_reg_read_en                = 1'b0;
    out_reg_rx_selector            = '0;
    out_reg_ry_selector            = '0;
    out_halted                     = 1'b0;
    out_illegal                    = 1'b0;
    // Outputs are forced low while reset is held, even though the state reads FETCH.
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          out_pc_enable_out = 1'b1;
          out_ir_load       = 1'b1;
          out_pc_inc        = 1'b1;
          state_d           = StDecode;
        end
        StDecode: begin
          state_d = (in_op == OpHalt) ? StHalt : StExec;
        end
        StExec: begin
          state_d = StFetch;
          retire  = 1'b1;
          case (op_q)
            OpMov: begin
              out_reg_read_en     = 1'b1;
              out_reg_write_en    = 1'b1;
              out_reg_rx_selector = rx_q;
              out_reg_ry_selector = ry_q;
            end
            OpLoad, OpStore: begin
              out_reg_read_en                = 1'b1;
              out_data_memory_addr_wr_enable = 1'b1;
              out_reg_ry_selector            = (op_q == OpLoad) ? ry_q : rx_q;
              state_d                        = StMem;
              retire                         = 1'b0;
            end
            OpSetmbs: begin
              out_reg_read_en     = 1'b1;
              out_mbs_wr_enable   = 1'b1;
              out_reg_ry_selector = ry_q;
            end
            OpJmp: begin
              out_ir_enable_read = 1'b1;
              out_pc_load        = 1'b1;
            end
            OpJcond: begin
              out_ir_enable_read = in_alu_flags[cond_q];
              out_pc_load        = in_alu_flags[cond_q];
            end
            OpNop, OpHalt: ;
            default: begin
              if (is_alu) begin
                out_alu_op          = op_q[2:0];
                out_alu_enable_out  = 1'b1;
                out_reg_write_en    = 1'b1;
                out_reg_rx_selector = rx_q;
                out_reg_ry_selector = ry_q;
              end else begin
                out_illegal = 1'b1;
              end
            end
          endcase
        end
        StMem: begin
          if (op_q == OpLoad) begin
            out_data_memory_read_enable = 1'b1;
            out_reg_write_en            = 1'b1;
            out_reg_rx_selector         = rx_q;
          end else begin
            out_reg_read_en           = 1'b1;
            out_data_memory_wr_enable = 1'b1;
            out_reg_ry_selector       = ry_q;
          end
          if (in_mem_ready) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else if (mem_cnt_q == TmoW'(MEM_TIMEOUT - 1)) begin
            state_d = StFetch;
            tmo_d   = 1'b1;
          end else begin
            mem_cnt_d = mem_cnt_q + 1'b1;
          end
        end
        StHalt: begin
          out_halted = 1'b1;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      cond_q    <= '0;
      mem_cnt_q <= '0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      tmo_q     <= tmo_d;
      if (state_q == StDecode) begin
        op_q   <= in_op;
        rx_q   <= in_ir[IR_W-OP_W-1 -: REG_SEL_W];
        ry_q   <= in_ir[IR_W-OP_W-REG_SEL_W-1 -: REG_SEL_W];
        cond_q <= in_ir[PC_W +: CondW];
      end
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_state         = state_q;
  assign out_mem_timeout   = tmo_q;
  assign out_retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each cycle's expected output vector is queued as stimulus is driven and
// compared against the DUT at the following falling edge.
module tb_multicycle_control_unit;

  localparam int unsigned CntW  = 4;
  localparam int unsigned MemTo = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_ir = '0;
  logic [3:0]  in_alu_flags = '0;
  logic        in_mem_ready = 1'b0;
  logic [2:0]  alu_op, st;
  logic        alu_en, pc_ld, pc_inc, pc_en, ir_ld, ir_rd, mbs, dm_rd, dm_wr, dm_ad, r_wr, r_rd;
  logic [2:0]  rx_sel, ry_sel;
  logic        halted, illegal, mem_tmo;
  logic [CntW-1:0] count;

  multicycle_control_unit #(.MEM_TIMEOUT(MemTo), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n), .in_ir(in_ir), .in_alu_flags(in_alu_flags),
    .in_mem_ready(in_mem_ready), .out_alu_op(alu_op), .out_alu_enable_out(alu_en),
    .out_pc_load(pc_ld), .out_pc_inc(pc_inc), .out_pc_enable_out(pc_en),
    .out_ir_load(ir_ld), .out_ir_enable_read(ir_rd), .out_mbs_wr_enable(mbs),
    .out_data_memory_read_enable(dm_rd), .out_data_memory_wr_enable(dm_wr),
    .out_data_memory_addr_wr_enable(dm_ad), .out_reg_write_en(r_wr),
    .out_reg_read_en(r_rd), .out_reg_rx_selector(rx_sel), .out_reg_ry_selector(ry_sel),
    .out_state(st), .out_halted(halted), .out_illegal(illegal),
    .out_mem_timeout(mem_tmo), .out_retired_count(count)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] EAlu = 12'h800, EPcLd = 12'h400, EPcInc = 12'h200, EPcEn = 12'h100;
  localparam logic [11:0] EIrLd = 12'h080, EIrRd = 12'h040, EMbs = 12'h020, EDmRd = 12'h010;
  localparam logic [11:0] EDmWr = 12'h008, EDmAd = 12'h004, ERWr = 12'h002, ERRd = 12'h001;

  int errors = 0;
  int checks = 0;
  int cnt = 0;
  logic tmo_pend = 1'b0;
  logic [30:0] exp_q[$];
  string tag_q[$];

  function automatic logic [30:0] obs();
    return {st, halted, illegal, mem_tmo, alu_op,
            alu_en, pc_ld, pc_inc, pc_en, ir_ld, ir_rd, mbs, dm_rd, dm_wr, dm_ad, r_wr, r_rd,
            rx_sel, ry_sel, count};
  endfunction

  function automatic logic [30:0] mk(logic [2:0] s, logic h, logic il, logic tm, logic [2:0] aop,
                                     logic [11:0] en, logic [2:0] xs, logic [2:0] ys);
    logic [CntW-1:0] c;
    c = CntW'(cnt);
    return {s, h, il, tm, aop, en, xs, ys, c};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [30:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check(tag_q.pop_front(), 64'(obs()), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  function automatic void bump();
    if (cnt < (1 << CntW) - 1) cnt++;
  endfunction

  // rdy_at: 0 = never ready, n>0 = ready on MEM cycle n, n<0 = stop driving after -n MEM cycles.
  task automatic run(input logic [15:0] ir, input logic [3:0] fl, input int rdy_at);
    logic [4:0]  op;
    logic [2:0]  rx, ry, aop, xs, ys;
    logic [1:0]  cond;
    logic [11:0] en;
    logic        il, mem, done;
    op = ir[15:11]; rx = ir[10:8]; ry = ir[7:5]; cond = ir[10:9];
    in_ir = ir; in_alu_flags = fl; in_mem_ready = 1'b0;
    cyc(mk(3'd0, 0, 0, tmo_pend, 3'd0, EPcEn | EIrLd | EPcInc, 3'd0, 3'd0), "fetch");
    tmo_pend = 1'b0;
    cyc(mk(3'd1, 0, 0, 0, 3'd0, 12'h0, 3'd0, 3'd0), "decode");
    if (op == 5'h0F) begin
      repeat (8) cyc(mk(3'd4, 1, 0, 0, 3'd0, 12'h0, 3'd0, 3'd0), "halt");
      return;
    end
    en = '0; aop = '0; xs = '0; ys = '0; il = 1'b0; mem = 1'b0;
    if (op < 5'h08) begin
      en = EAlu | ERWr; aop = op[2:0]; xs = rx; ys = ry;
    end else begin
      case (op)
        5'h08: begin en = ERRd | ERWr; xs = rx; ys = ry; end
        5'h09: begin en = ERRd | EDmAd; ys = ry; mem = 1'b1; end
        5'h0A: begin en = ERRd | EDmAd; ys = rx; mem = 1'b1; end
        5'h0B: begin en = ERRd | EMbs; ys = ry; end
        5'h0C: en = EIrRd | EPcLd;
        5'h0D: if (fl[cond]) en = EIrRd | EPcLd;
        5'h0E: ;
        default: il = 1'b1;
      endcase
    end
    cyc(mk(3'd2, 0, il, 0, aop, en, xs, ys), "exec");
    if (!mem) begin
      bump();
      return;
    end
    done = 1'b0;
    for (int i = 1; i <= int'(MemTo) && !done; i++) begin
      if (rdy_at < 0 && i > -rdy_at) return;
      in_mem_ready = (i == rdy_at);
      if (op == 5'h09) cyc(mk(3'd3, 0, 0, 0, 3'd0, EDmRd | ERWr, rx, 3'd0), "mem_load");
      else             cyc(mk(3'd3, 0, 0, 0, 3'd0, ERRd | EDmWr, 3'd0, ry), "mem_store");
      if (i == rdy_at) begin
        bump();
        done = 1'b1;
      end
    end
    in_mem_ready = 1'b0;
    if (!done) tmo_pend = 1'b1;
  endtask

  initial begin
    #2;
    check("reset_outputs", 64'(obs()), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(16'h0000, 4'h0, 0);   // ALU op0, rx0
    run(16'h2BC0, 4'h0, 0);   // ALU op5 rx3 ry6
    run(16'h41E0, 4'h0, 0);   // MOV rx1 ry7
    run(16'h4AA0, 4'h0, 3);   // LOAD rx2 ry5, ready on 3rd MEM cycle
    run(16'h5420, 4'h0, 0);   // STORE rx4 ry1, never ready
    run(16'h5860, 4'h0, 0);   // SETMBS ry3 (sees timeout pulse in its FETCH)
    run(16'h6000, 4'h0, 0);   // JMP
    run(16'h6A00, 4'b0010, 0); // JCOND cond1 taken
    run(16'h6A00, 4'b0000, 0); // JCOND cond1 not taken
    run(16'h5420, 4'h0, 1);   // STORE ready immediately
    run(16'h4AA0, 4'h0, int'(MemTo)); // LOAD ready on the last allowed cycle
    run(16'hF800, 4'h0, 0);   // opcode 0x1F illegal
    run(16'h8000, 4'h0, 0);   // opcode 0x10 illegal
    repeat (6) run(16'h7000, 4'h0, 0); // NOPs drive count into saturation
    check("count_saturated", 64'(cnt), 64'((1 << CntW) - 1));
    run(16'h4AA0, 4'h0, -2);  // LOAD stalled in MEM, reset mid-access
    #2 rst_n = 1'b0;
    #1 check("reset_mid_mem", 64'(obs()), 64'h0);
    cnt = 0; tmo_pend = 1'b0; in_ir = '0;
    @(posedge clk);
    #1 check("reset_held", 64'(obs()), 64'h0);
    rst_n = 1'b1;
    run(16'h7000, 4'h0, 0);   // NOP after reset
    run(16'h7800, 4'h0, 0);   // HALT
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- IR_W, 16: instruction width.
- OP_W, 5: opcode width, taken from in_ir[IR_W-1 -: OP_W].
- REG_SEL_W, 3: register selector width.
- PC_W, 9: jump target width, taken from in_ir[PC_W-1:0].
- FLAGS_W, 4: ALU flag count.
- MEM_TIMEOUT, 15: maximum wait cycles for a data-memory access.
- CNT_W, 16: retired-instruction counter width.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset; one clock; reset is asynchronous and active-low.
- in_ir, in, IR_W: instruction register contents.
- in_alu_flags, in, FLAGS_W: ALU flags.
- in_mem_ready, in, 1: data-memory access complete.
- out_alu_op, out, 3: ALU operation.
- out_alu_enable_out, out, 1: ALU drives bus.
- out_pc_load, out, 1: PC loads from bus.
- out_pc_inc, out, 1: PC increments.
- out_pc_enable_out, out, 1: PC addresses code memory.
- out_ir_load, out, 1: IR loads code-memory output.
- out_ir_enable_read, out, 1: IR jump field drives bus.
- out_mbs_wr_enable, out, 1: memory bank selector loads from bus.
- out_data_memory_read_enable, out, 1: data memory drives bus.
- out_data_memory_wr_enable, out, 1: data memory writes from bus.
- out_data_memory_addr_wr_enable, out, 1: data address register loads from bus.
- out_reg_write_en, out, 1: write bus into register rx_sel.
- out_reg_read_en, out, 1: register ry_sel drives bus.
- out_reg_rx_selector, out, REG_SEL_W: write/ALU-A register select.
- out_reg_ry_selector, out, REG_SEL_W: read/ALU-B register select.
- out_state, out, 3: FSM state encoding.
- out_halted, out, 1: FSM in HALT.
- out_illegal, out, 1: one-cycle pulse on illegal opcode.
- out_mem_timeout, out, 1: one-cycle pulse on access abort.
- out_retired_count, out, CNT_W: retired instructions, saturating.
REQ-003 SHALL elaborate only if OP_W>=4 and OP_W+2*REG_SEL_W<=IR_W and OP_W+PC_W+clog2(FLAGS_W)<=IR_W.

Function
REQ-004 SHALL decode fields: op = top OP_W bits; rx = next REG_SEL_W bits; ry = following REG_SEL_W bits; cond = in_ir[PC_W +: clog2(FLAGS_W)].
REQ-005 SHALL use opcodes 0x00-0x07 ALU (alu_op=op[2:0]), 0x08 MOV, 0x09 LOAD, 0x0A STORE, 0x0B SETMBS, 0x0C JMP, 0x0D JCOND, 0x0E NOP, 0x0F HALT; all others illegal.
REQ-006 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4; controls Moore-decoded from state and latched-in IR.
REQ-007 SHALL in FETCH assert pc_enable_out, ir_load, pc_inc for one cycle; -> DECODE.
REQ-008 SHALL in DECODE assert no control output; -> HALT if HALT, else EXEC.
REQ-009 SHALL in EXEC, per opcode:
- ALU: alu_enable_out + reg_write_en, rx_sel=rx, ry_sel=ry.
- MOV: reg_read_en + reg_write_en, rx_sel=rx, ry_sel=ry.
- SETMBS: reg_read_en + mbs_wr_enable, ry_sel=ry.
- JMP: ir_enable_read + pc_load.
- JCOND: JMP controls only if in_alu_flags[cond]=1, else none.
- LOAD: reg_read_en + addr_wr_enable, ry_sel=ry; -> MEM.
- STORE: reg_read_en + addr_wr_enable, ry_sel=rx; -> MEM.
- NOP/illegal: none; illegal also pulses out_illegal.
- All non-memory opcodes -> FETCH.
REQ-010 SHALL in MEM:
- LOAD: hold data_memory_read_enable + reg_write_en (rx_sel=rx).
- STORE: hold reg_read_en + data_memory_wr_enable (ry_sel=ry).
- Exit -> FETCH on the cycle in_mem_ready=1; controls are asserted that cycle.
REQ-011 SHALL count MEM cycles; if MEM_TIMEOUT cycles pass without ready, deassert all, pulse out_mem_timeout, -> FETCH; counter clears on MEM entry.
REQ-012 SHALL assert at most one bus driver per cycle: alu_enable_out, pc-to-bus, ir_enable_read, reg_read_en, data_memory_read_enable.
REQ-013 SHALL increment out_retired_count on each EXEC->FETCH or MEM->FETCH exit with success, illegal included, timeout excluded; saturates at all-ones.
REQ-014 SHALL in HALT hold all controls low and out_halted=1 until reset.
REQ-015 SHALL drive selectors to 0 in states where no register is accessed.

Reset
REQ-016 SHALL on rst_n=0, immediately and regardless of state (including mid-MEM):
- State -> FETCH.
- All enables, selectors, out_alu_op, pulses, counters, out_halted -> 0.
REQ-017 SHALL begin FETCH on the first rising edge after rst_n release.

Verification
REQ-018 SHALL cover these directed scenarios:
- Reset release, in_ir=0x0000 (ALU op 0), rx=0 -> FETCH, DECODE, EXEC with alu_enable_out+reg_write_en, alu_op=0; count=1 after 3 cycles.
- LOAD rx=2, ry=5, in_mem_ready high on 3rd MEM cycle -> read_enable+reg_write_en for 3 cycles, rx_sel=2; back to FETCH.
- STORE with in_mem_ready never high -> exactly MEM_TIMEOUT MEM cycles; out_mem_timeout pulse; count unchanged.
- JCOND cond=1 with flags=4'b0010 -> pc_load=1; with flags=4'b0000 -> pc_load=0.
- Opcode 0x1F -> out_illegal pulse for 1 cycle; count increments. Opcode 0x0F -> out_halted=1 indefinitely, no enables.
- rst_n low during MEM -> all outputs 0 asynchronously; FETCH after release.
